pixel_packer: RTL

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pixel_packer.sv
// Pixel packer: gathers 8-bit filtered pixels into little-endian 32-bit words and
// presents them, with incrementing byte addresses, on a valid/ready write port.
// One frame of IMG_W*IMG_H pixels is packed per accepted start pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle frame-start pulse (honoured in idle only)
//   base_addr  frame byte base address, captured on accepted start
//   pix_valid  pixel present          pix_data  pixel value
//   pix_ready  pixel accepted this cycle
//   wr_valid   write word present     wr_ready  sink accepts word
//   wr_addr    word byte address      wr_data   packed word
//   busy       frame in progress      done      one-cycle frame-complete pulse
module pixel_packer #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned Total = IMG_W * IMG_H;
  // Counter holds the index of the next pixel, 0 .. Total-1.
  localparam int unsigned CntW = (Total > 1) ? $clog2(Total) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Total - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     off_q, off_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [23:0]     pack_q, pack_d;
  logic            wr_valid_q, wr_valid_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;

  logic [31:0] word;
  logic        last_pix;
  logic        word_end;
  logic        pix_xfer;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pack_d     = pack_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // Collected bytes above the current index are always zero, so a short
    // final word comes out with its unused upper bytes cleared.
    word = {8'h00, pack_q};
    word[{idx_q, 3'b000} +: 8] = pix_data;

    last_pix = (cnt_q == LastIdx);
    word_end = (idx_q == 2'd3) || last_pix;

    // Stall only the pixel that would need the output register while it is
    // still occupied by a word the sink has not taken.
    pix_ready = (state_q == StRun) && !(word_end && wr_valid_q && !wr_ready);
    pix_xfer  = pix_valid && pix_ready;

    if (wr_valid_q && wr_ready) begin
      wr_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          base_d  = base_addr;
          off_d   = 32'd0;
          cnt_d   = '0;
          idx_d   = 2'd0;
          pack_d  = 24'd0;
        end
      end
      StRun: begin
        if (pix_xfer) begin
          cnt_d  = cnt_q + CntW'(1);
          idx_d  = idx_q + 2'd1;
          pack_d = word[23:0];
          if (word_end) begin
            // Overrides the drain above when the old word leaves this cycle.
            wr_valid_d = 1'b1;
            wr_addr_d  = base_q + off_q;
            wr_data_d  = word;
            off_d      = off_q + 32'd4;
            idx_d      = 2'd0;
            pack_d     = 24'd0;
          end
          if (last_pix) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!wr_valid_q || wr_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= 32'd0;
      off_q      <= 32'd0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pack_q     <= 24'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pack_q     <= pack_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule
